// File: rtl/fetch_buffer_if.sv
// Bus bundle between fetch_buffer, the local store and decode.
// The master side belongs to fetch_buffer. The slave side belongs to the memory and decode.
interface fetch_buffer_if #(
  parameter int unsigned INSTR_W = 32
);
  logic                   mem_rd_en;
  logic [0:8]             mem_addr;
  logic [0:2*INSTR_W-1]   mem_rdata;
  logic                   dec_ready;
  logic                   out_valid;
  logic [0:INSTR_W-1]     out_instr0;
  logic [0:INSTR_W-1]     out_instr1;
  logic [0:9]             out_pc;
  logic                   out_slot0_vld;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rdata,
    input  dec_ready,
    output out_valid, out_instr0, out_instr1, out_pc, out_slot0_vld
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rdata,
    output dec_ready,
    input  out_valid, out_instr0, out_instr1, out_pc, out_slot0_vld
  );
endinterface

// File: rtl/fetch_buffer.sv
// Fetch stage: issues one pair read per cycle and queues PC-tagged pairs for decode.
// A taken branch flushes the queue and the in-flight read.
module fetch_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PTR_W   = 2,
  parameter int unsigned INSTR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [0:9]     pc_in,
  input  logic           flush,
  output logic           pc_stall,
  fetch_buffer_if.master bus
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [0:INSTR_W-1] instr0;
    logic [0:INSTR_W-1] instr1;
    logic [0:9]         pc;
    logic               slot0_vld;
  } entry_t;

  entry_t             fifo_q [DEPTH];
  entry_t             fifo_d [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               inflight_q, inflight_d;
  logic [0:8]         infl_pc_q, infl_pc_d;
  logic               infl_odd_q, infl_odd_d;

  logic [CNT_W-1:0]   occ;
  logic               issue, push, pop, out_valid;
  entry_t             head, push_entry;

  assign out_valid = (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];

  // Occupancy includes the in-flight read, so a push can never overflow the queue.
  always_comb begin
    occ      = count_q + CNT_W'(inflight_q);
    pc_stall = ~flush & (occ >= CNT_W'(DEPTH));
    issue    = rst & ~pc_stall & ~flush;
    push     = inflight_q & ~flush;
    pop      = out_valid & bus.dec_ready & ~flush;
    push_entry = '{instr0:    bus.mem_rdata[0:INSTR_W-1],
                   instr1:    bus.mem_rdata[INSTR_W:2*INSTR_W-1],
                   pc:        {infl_pc_q, 1'b0},
                   slot0_vld: ~infl_odd_q};
  end

  always_comb begin
    fifo_d     = fifo_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = issue;
    infl_pc_d  = issue ? pc_in[0:8] : infl_pc_q;
    infl_odd_d = issue ? pc_in[9]   : infl_odd_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = push_entry;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      infl_pc_q  <= '0;
      infl_odd_q <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      infl_pc_q  <= infl_pc_d;
      infl_odd_q <= infl_odd_d;
    end
  end

  always_comb begin
    bus.mem_rd_en     = issue;
    bus.mem_addr      = pc_in[0:8];
    bus.out_valid     = out_valid;
    bus.out_instr0    = head.instr0;
    bus.out_instr1    = head.instr1;
    bus.out_pc        = head.pc;
    bus.out_slot0_vld = head.slot0_vld;
  end

endmodule
